// File: rtl/resblock_skip_add.sv
// resblock_skip_add
// Residual join stage that sits after the resblock conv path. The resblock's
// input tiles (skip path) wait in a FIFO until the matching conv output tile
// arrives. The two tiles are then added lane by lane with saturation, and the
// sum is registered on the output. The last tile of each frame is flagged.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   skip_in*          skip tile stream (valid/ready), N lanes of IN_WIDTH
//   conv_in*          conv tile stream (valid/ready), N lanes of CONV_WIDTH
//   data_out_0*       residual sum stream (valid/ready/last), N lanes of OUT_WIDTH
//   sat_seen          sticky flag: some lane has clipped since reset
//
// Lane i of every tile bus occupies bits [i*W +: W].
module resblock_skip_add #(
    parameter int COMPUTE_DIM0    = 2,
    parameter int COMPUTE_DIM1    = 2,
    parameter int IN_WIDTH        = 8,
    parameter int IN_FRAC_WIDTH   = 4,
    parameter int CONV_WIDTH      = 8,
    parameter int CONV_FRAC_WIDTH = 4,
    parameter int OUT_WIDTH       = 8,
    parameter int OUT_FRAC_WIDTH  = 4,
    parameter int SKIP_FIFO_DEPTH = 8,
    parameter int TILES_PER_FRAME = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [COMPUTE_DIM0*COMPUTE_DIM1*IN_WIDTH-1:0]   skip_in,
    input  logic                                           skip_in_valid,
    output logic                                           skip_in_ready,
    input  logic [COMPUTE_DIM0*COMPUTE_DIM1*CONV_WIDTH-1:0] conv_in,
    input  logic                                           conv_in_valid,
    output logic                                           conv_in_ready,
    output logic [COMPUTE_DIM0*COMPUTE_DIM1*OUT_WIDTH-1:0]  data_out_0,
    output logic                                           data_out_0_valid,
    input  logic                                           data_out_0_ready,
    output logic                                           data_out_0_last,
    output logic                                           sat_seen
);

    localparam int N       = COMPUTE_DIM0 * COMPUTE_DIM1;
    localparam int AW      = (SKIP_FIFO_DEPTH > 1) ? $clog2(SKIP_FIFO_DEPTH) : 1;
    localparam int EXT     = OUT_WIDTH + 2;
    localparam int SKIP_SH = OUT_FRAC_WIDTH - IN_FRAC_WIDTH;
    localparam int CONV_SH = OUT_FRAC_WIDTH - CONV_FRAC_WIDTH;
    localparam int CW      = (TILES_PER_FRAME > 1) ? $clog2(TILES_PER_FRAME) : 1;

    localparam logic [CW-1:0] LAST_TILE = CW'(TILES_PER_FRAME - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(SKIP_FIFO_DEPTH);

    // Saturation bounds of the output format, expressed in the extended width.
    localparam logic signed [EXT-1:0] SAT_MAX = {{3{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT-1:0] SAT_MIN = {{3{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Reject parameter sets that the shift-only alignment cannot handle.
    if (OUT_FRAC_WIDTH < IN_FRAC_WIDTH || OUT_FRAC_WIDTH < CONV_FRAC_WIDTH) begin : g_frac_check
        $error("resblock_skip_add: OUT_FRAC_WIDTH must be >= IN_FRAC_WIDTH and CONV_FRAC_WIDTH");
    end
    if (SKIP_FIFO_DEPTH < 2 || (SKIP_FIFO_DEPTH & (SKIP_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("resblock_skip_add: SKIP_FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (TILES_PER_FRAME < 1) begin : g_frame_check
        $error("resblock_skip_add: TILES_PER_FRAME must be >= 1");
    end

    logic [N*IN_WIDTH-1:0] fifo_mem [SKIP_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_nonempty;
    logic                  push;
    logic                  pop;
    logic                  out_free;
    logic                  load;
    logic [N*IN_WIDTH-1:0] skip_head;
    logic [N*OUT_WIDTH-1:0] sum_tile;
    logic [N-1:0]          lane_sat;
    logic [CW-1:0]         tile_cnt;

    // Emptiness comes from the registered count, so a tile written this cycle
    // cannot be popped until the next one.
    assign fifo_full     = (fifo_count == FIFO_FULL);
    assign fifo_nonempty = (fifo_count != '0);
    assign skip_in_ready = !fifo_full;
    assign push          = skip_in_valid && !fifo_full;

    assign out_free      = !data_out_0_valid || data_out_0_ready;
    assign conv_in_ready = fifo_nonempty && out_free;
    assign load          = fifo_nonempty && conv_in_valid && out_free;
    assign pop           = load;

    assign skip_head     = fifo_mem[rd_ptr];

    // The tile storage has no reset. After a reset the count is zero,
    // so the old contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= skip_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Per-lane add. Both operands are widened to OUT_WIDTH+2 bits so the sum of
    // two in-range values cannot wrap before the range check.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [EXT-1:0] skip_ext;
        logic signed [EXT-1:0] conv_ext;
        logic signed [EXT-1:0] sum_ext;
        logic                  over;
        logic                  under;

        assign skip_ext = EXT'(signed'(skip_head[i*IN_WIDTH +: IN_WIDTH])) <<< SKIP_SH;
        assign conv_ext = EXT'(signed'(conv_in[i*CONV_WIDTH +: CONV_WIDTH])) <<< CONV_SH;
        assign sum_ext  = skip_ext + conv_ext;
        assign over     = (sum_ext > SAT_MAX);
        assign under    = (sum_ext < SAT_MIN);
        assign lane_sat[i] = over || under;
        assign sum_tile[i*OUT_WIDTH +: OUT_WIDTH] =
            over  ? SAT_MAX[OUT_WIDTH-1:0] :
            under ? SAT_MIN[OUT_WIDTH-1:0] :
                    sum_ext[OUT_WIDTH-1:0];
    end

    // Output register. The last flag travels with the data, and the frame
    // counter advances only when a tile is actually loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_0       <= '0;
            data_out_0_valid <= 1'b0;
            data_out_0_last  <= 1'b0;
            sat_seen         <= 1'b0;
            tile_cnt         <= '0;
        end else if (load) begin
            data_out_0       <= sum_tile;
            data_out_0_valid <= 1'b1;
            data_out_0_last  <= (tile_cnt == LAST_TILE);
            sat_seen         <= sat_seen || (|lane_sat);
            tile_cnt         <= (tile_cnt == LAST_TILE) ? '0 : tile_cnt + 1'b1;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_resblock_skip_add.sv
// tb_resblock_skip_add
// Directed testbench for resblock_skip_add with its default parameters:
// 2x2 tiles, 8-bit Q4.4 lanes, a FIFO depth of 8 and 8 tiles per frame.
// Inputs change on the falling edge. Outputs are sampled 1 time unit later,
// well away from the rising edge that updates the design.
module tb_resblock_skip_add;

    logic        clk;
    logic        rst;
    logic [31:0] skip_in;
    logic        skip_in_valid;
    logic        skip_in_ready;
    logic [31:0] conv_in;
    logic        conv_in_valid;
    logic        conv_in_ready;
    logic [31:0] data_out_0;
    logic        data_out_0_valid;
    logic        data_out_0_ready;
    logic        data_out_0_last;
    logic        sat_seen;

    int checks = 0;
    int errors = 0;
    int tile_idx = 0;

    resblock_skip_add dut (
        .clk              (clk),
        .rst              (rst),
        .skip_in          (skip_in),
        .skip_in_valid    (skip_in_valid),
        .skip_in_ready    (skip_in_ready),
        .conv_in          (conv_in),
        .conv_in_valid    (conv_in_valid),
        .conv_in_ready    (conv_in_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .data_out_0_last  (data_out_0_last),
        .sat_seen         (sat_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    // Wait for the falling edge, drive every input, then let the
    // combinational outputs settle before any checks.
    task automatic applyStimulus(input logic [31:0] s, input logic sv,
                                 input logic [31:0] c, input logic cv,
                                 input logic rdy);
        @(negedge clk);
        skip_in          = s;
        skip_in_valid    = sv;
        conv_in          = c;
        conv_in_valid    = cv;
        data_out_0_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one newly presented output tile. Every 8th tile must carry last.
    task automatic checkTile(input string tag, input logic [31:0] exp);
        checkOutput({tag, "_valid"}, 32'(data_out_0_valid), 32'd1);
        checkOutput({tag, "_data"}, data_out_0, exp);
        checkOutput({tag, "_last"}, 32'(data_out_0_last), 32'((tile_idx % 8) == 7));
        tile_idx++;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("rst_valid", 32'(data_out_0_valid), 32'd0);
        checkOutput("rst_data", data_out_0, 32'h0);
        checkOutput("rst_last", 32'(data_out_0_last), 32'd0);
        checkOutput("rst_sat", 32'(sat_seen), 32'd0);
        checkOutput("rst_skip_rdy", 32'(skip_in_ready), 32'd1);
        checkOutput("rst_conv_rdy", 32'(conv_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic add: 1.5 + 2.25 = 3.75 (0x3C). The conv tile stalls until the skip tile is poppable.
        $display("[TB] basic add");
        applyStimulus(rep(8'h18), 1'b1, rep(8'h24), 1'b1, 1'b1);
        checkOutput("basic_conv_stall", 32'(conv_in_ready), 32'd0);
        applyStimulus(rep(8'h00), 1'b0, rep(8'h24), 1'b1, 1'b1);
        checkOutput("basic_conv_rdy", 32'(conv_in_ready), 32'd1);
        checkOutput("basic_not_yet", 32'(data_out_0_valid), 32'd0);
        applyStimulus(rep(8'h00), 1'b0, rep(8'h00), 1'b0, 1'b1);
        checkTile("basic", rep(8'h3C));
        checkOutput("basic_sat", 32'(sat_seen), 32'd0);
        applyStimulus(rep(8'h00), 1'b0, rep(8'h00), 1'b0, 1'b1);
        checkOutput("basic_drop", 32'(data_out_0_valid), 32'd0);

        // Saturation in both directions; sat_seen is sticky.
        $display("[TB] saturation");
        applyStimulus(rep(8'h70), 1'b1, rep(8'h00), 1'b0, 1'b1);
        applyStimulus(rep(8'h80), 1'b1, rep(8'h20), 1'b1, 1'b1);
        applyStimulus(rep(8'h00), 1'b0, rep(8'hF0), 1'b1, 1'b1);
        checkTile("sat_pos", rep(8'h7F));
        checkOutput("sat_pos_flag", 32'(sat_seen), 32'd1);
        applyStimulus(rep(8'h00), 1'b0, rep(8'h00), 1'b0, 1'b1);
        checkTile("sat_neg", rep(8'h80));
        applyStimulus(rep(8'h00), 1'b0, rep(8'h00), 1'b0, 1'b1);
        checkOutput("sat_sticky", 32'(sat_seen), 32'd1);

        // Mixed lanes: 0x01+0x02, 0x7F+0x01 (clip), 0x80+0xFF (clip), 0x10+0xF0 = 0.
        $display("[TB] mixed lanes");
        applyStimulus(32'h10807F01, 1'b1, 32'hF0FF0102, 1'b1, 1'b1);
        applyStimulus(32'h0, 1'b0, 32'hF0FF0102, 1'b1, 1'b1);
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkTile("mixed", 32'h00807F03);

        // Fill the FIFO, then drain it in order at one tile per cycle.
        $display("[TB] fifo full");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(rep(8'(k + 1)), 1'b1, rep(8'h00), 1'b0, 1'b1);
            checkOutput("fill_skip_rdy", 32'(skip_in_ready), 32'd1);
        end
        applyStimulus(rep(8'h00), 1'b0, rep(8'h00), 1'b1, 1'b1);
        checkOutput("full_skip_rdy", 32'(skip_in_ready), 32'd0);
        checkOutput("full_conv_rdy", 32'(conv_in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(rep(8'h00), 1'b0, rep(8'h00), (k < 7), 1'b1);
            if (k == 0) begin
                checkOutput("unfull_skip_rdy", 32'(skip_in_ready), 32'd1);
            end
            checkTile("drain", rep(8'(k + 1)));
        end

        // Backpressure: the output stays stable and no conv tile is taken while ready is low.
        $display("[TB] backpressure");
        applyStimulus(rep(8'h11), 1'b1, rep(8'h01), 1'b0, 1'b0);
        applyStimulus(rep(8'h22), 1'b1, rep(8'h01), 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(rep(8'h33), 1'b1, rep(8'h01), 1'b1, 1'b0);
            if (s == 0) begin
                checkTile("bp_first", rep(8'h12));
            end else begin
                checkOutput("bp_hold_valid", 32'(data_out_0_valid), 32'd1);
                checkOutput("bp_hold_data", data_out_0, rep(8'h12));
            end
            checkOutput("bp_conv_rdy", 32'(conv_in_ready), 32'd0);
        end
        applyStimulus(rep(8'h00), 1'b0, rep(8'h01), 1'b1, 1'b1);
        checkOutput("bp_release_rdy", 32'(conv_in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(rep(8'h00), 1'b0, rep(8'h01), (k < 5), 1'b1);
            checkTile("bp_stream", (k == 0) ? rep(8'h23) : rep(8'h34));
        end
        checkOutput("bp_empty_stall", 32'(conv_in_ready), 32'd0);

        // Reset with three tiles buffered and a held output; nothing may survive it.
        $display("[TB] reset mid-stream");
        applyStimulus(rep(8'h41), 1'b1, rep(8'h01), 1'b1, 1'b0);
        applyStimulus(rep(8'h42), 1'b1, rep(8'h01), 1'b1, 1'b0);
        applyStimulus(rep(8'h43), 1'b1, rep(8'h01), 1'b1, 1'b0);
        applyStimulus(rep(8'h44), 1'b1, rep(8'h01), 1'b1, 1'b0);
        applyStimulus(rep(8'h00), 1'b0, rep(8'h01), 1'b1, 1'b0);
        checkOutput("pre_rst_data", data_out_0, rep(8'h42));
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(data_out_0_valid), 32'd0);
        checkOutput("mid_rst_data", data_out_0, 32'h0);
        checkOutput("mid_rst_last", 32'(data_out_0_last), 32'd0);
        checkOutput("mid_rst_sat", 32'(sat_seen), 32'd0);
        checkOutput("mid_rst_conv_rdy", 32'(conv_in_ready), 32'd0);
        applyStimulus(rep(8'h00), 1'b0, rep(8'h01), 1'b1, 1'b1);
        rst = 1'b0;
        tile_idx = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(rep(8'h00), 1'b0, rep(8'h01), 1'b1, 1'b1);
            checkOutput("post_rst_stall", 32'(conv_in_ready), 32'd0);
            checkOutput("post_rst_valid", 32'(data_out_0_valid), 32'd0);
        end

        // Frame: 16 streamed tiles. The first one also shows that the flushed FIFO held no stale tile.
        $display("[TB] frame");
        for (int k = 0; k < 18; k++) begin
            applyStimulus(rep(8'(2 * k)), (k < 16), rep(8'h01), (k < 17), 1'b1);
            if (k == 0) begin
                checkOutput("frame_conv_stall", 32'(conv_in_ready), 32'd0);
            end
            if (k >= 2) begin
                checkTile("frame", rep(8'(2 * (k - 2) + 1)));
            end
        end
        applyStimulus(rep(8'h00), 1'b0, rep(8'h00), 1'b0, 1'b1);
        checkOutput("frame_end_valid", 32'(data_out_0_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
